// File: rtl/uart_alu_result_tx.sv
// Return path of the UART-ALU datapath: latches one ALU result and hands it
// to uart_transmitter one byte at a time over the start/busy/done handshake.
module uart_alu_result_tx #(
  parameter int NB_OUT    = 16,
  parameter int NB_DATA   = 8,
  parameter int MSB_FIRST = 0
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic [NB_OUT-1:0]  i_result,
  input  logic               i_tx_busy,
  input  logic               i_tx_done,
  output logic               o_tx_start,
  output logic [NB_DATA-1:0] o_tx_data,
  output logic               o_busy,
  output logic               o_done
);

  localparam int NB_BYTES = (NB_OUT + NB_DATA - 1) / NB_DATA;
  localparam int NB_SHIFT = NB_BYTES * NB_DATA;
  localparam int NB_CNT   = (NB_BYTES > 1) ? $clog2(NB_BYTES) : 1;
  localparam logic [NB_CNT-1:0] LAST_BYTE = NB_CNT'(NB_BYTES - 1);

  typedef enum logic [1:0] {IDLE, SEND, WAIT, DONE} state_t;

  state_t              state, state_next;
  logic [NB_SHIFT-1:0] shift_reg, shift_next, shift_adv;
  logic [NB_CNT-1:0]   byte_cnt, cnt_next;
  logic [NB_DATA-1:0]  cur_byte, data_next;
  logic                start_next;

  // The byte on the sending end; advancing moves the next byte onto that end.
  assign cur_byte  = (MSB_FIRST != 0) ? shift_reg[NB_SHIFT-1 -: NB_DATA]
                                      : shift_reg[NB_DATA-1:0];
  assign shift_adv = (MSB_FIRST != 0) ? (shift_reg << NB_DATA)
                                      : (shift_reg >> NB_DATA);

  always_comb begin
    state_next = state;
    shift_next = shift_reg;
    cnt_next   = byte_cnt;
    start_next = 1'b0;
    data_next  = o_tx_data;
    case (state)
      IDLE: begin
        if (i_start) begin
          shift_next = NB_SHIFT'(i_result);
          cnt_next   = '0;
          state_next = SEND;
        end
      end
      SEND: begin
        if (!i_tx_busy) begin
          start_next = 1'b1;
          data_next  = cur_byte;
          state_next = WAIT;
        end
      end
      WAIT: begin
        if (i_tx_done) begin
          if (byte_cnt == LAST_BYTE) begin
            state_next = DONE;
          end else begin
            cnt_next   = byte_cnt + NB_CNT'(1);
            shift_next = shift_adv;
            state_next = SEND;
          end
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Status outputs are registered from the next state so they line up with it.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state      <= IDLE;
      shift_reg  <= '0;
      byte_cnt   <= '0;
      o_tx_start <= 1'b0;
      o_tx_data  <= '0;
      o_busy     <= 1'b0;
      o_done     <= 1'b0;
    end else begin
      state      <= state_next;
      shift_reg  <= shift_next;
      byte_cnt   <= cnt_next;
      o_tx_start <= start_next;
      o_tx_data  <= data_next;
      o_busy     <= (state_next != IDLE);
      o_done     <= (state_next == DONE);
    end
  end

endmodule

// File: doc/uart_alu_result_tx.md
Name: uart_alu_result_tx

Overview:
- Return path of the UART–ALU datapath. Captures one NB_OUT-bit ALU result when the ALU interface flags it valid.
- Splits the result into NB_DATA-bit bytes and feeds them one at a time to uart_transmitter using its start/busy/done handshake.
- Sits between the ALU output and uart_transmitter i_data/i_tx_start. Full results of any width are returned to the host.

Parameters:
- NB_OUT, 16, ALU result width in bits.
- NB_DATA, 8, UART byte width in bits.
- MSB_FIRST, 0, byte order: 0 sends the least-significant byte first, 1 sends the most-significant byte first.
- NB_BYTES, ceil(NB_OUT/NB_DATA) (derived localparam, not overridable), number of bytes per frame.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  synchronous active-high reset.
- i_start  in  1  result-valid pulse from the ALU interface (o_data_ready).
- i_result  in  NB_OUT  ALU result, sampled only when i_start is accepted.
- i_tx_busy  in  1  uart_transmitter o_tx_transmiting.
- i_tx_done  in  1  uart_transmitter o_tx_done, one-cycle pulse at end of a byte.
- o_tx_start  out  1  one-cycle start pulse to uart_transmitter.
- o_tx_data  out  NB_DATA  byte to transmit; held stable from o_tx_start until the matching i_tx_done.
- o_busy  out  1  frame in progress; high whenever state is not IDLE.
- o_done  out  1  one-cycle pulse after the last byte's i_tx_done.

Behaviour:
- One clock domain, i_clk. Reset is synchronous and active-high.
- All outputs are registered. Reset values: o_tx_start=0, o_tx_data=0, o_busy=0, o_done=0, state=IDLE, byte counter=0, shift register=0.
- FSM states: IDLE, SEND, WAIT, DONE.
- IDLE: when i_start=1, latch i_result into the shift register, zero-extended to NB_BYTES*NB_DATA bits. Clear the byte counter, go to SEND. While not in IDLE, i_start is ignored (no queueing).
- SEND:
  - If i_tx_busy=1, hold in SEND with o_tx_start=0.
  - If i_tx_busy=0, set o_tx_start=1 for one cycle and load o_tx_data with the current byte, then go to WAIT.
  - Current byte is the low NB_DATA bits of the shift register when MSB_FIRST=0, the high NB_DATA bits when MSB_FIRST=1.
- WAIT: o_tx_start=0. Ignore everything until i_tx_done=1. On i_tx_done:
  - If byte counter = NB_BYTES-1, go to DONE.
  - Otherwise increment the counter, shift the register by NB_DATA toward the sending end, and go to SEND.
- DONE: o_done=1 for exactly one cycle, then go to IDLE. o_busy drops in the same cycle o_done drops.
- Latency:
  - i_start high in cycle 0, with i_tx_busy low: o_busy=1 in cycle 1, o_tx_start=1 in cycle 2.
  - Each later byte: o_tx_start fires 2 cycles after the previous i_tx_done, provided i_tx_busy is low.
- i_tx_done outside WAIT (stale pulse) is ignored and never advances the counter.
- i_tx_done and i_start in the same cycle while not IDLE: i_start is dropped.
- Reset mid-frame (any state): next cycle is IDLE with all outputs at reset values. No o_done is produced for the aborted frame.
- NB_OUT not a multiple of NB_DATA: unused upper bits of the last byte are sent as 0.
- o_tx_data holds its last value while in IDLE.

Test Plan:
- Basic LSB-first (defaults), transmitter model with 10-cycle byte time:
  - Stimulus: i_result=16'hA55A, i_start pulse.
  - Required: o_tx_start pulses twice, o_tx_data=8'h5A then 8'hA5. o_done pulses once, 1 cycle after the second i_tx_done. o_busy is high from cycle 1 until o_done drops.
- MSB_FIRST=1:
  - Stimulus: i_result=16'h1234.
  - Required: bytes 8'h12 then 8'h34. First o_tx_start in cycle 2 after i_start.
- NB_OUT=12:
  - Stimulus: i_result=12'hABC.
  - Required: bytes 8'hBC then 8'h0A (zero-padded). Exactly 2 start pulses.
- Busy back-pressure:
  - Stimulus: hold i_tx_busy=1 for 20 cycles after i_start.
  - Required: o_tx_start stays 0 and fires in the cycle after i_tx_busy falls. o_tx_data is correct.
- Overlap and stray events:
  - Stimulus: i_start=1 with i_result=16'hFFFF during a frame of 16'h0102; a stray i_tx_done while in SEND.
  - Required: frame still sends 8'h02, 8'h01. The second result is not sent. The stray done does not skip a byte.
- Reset mid-frame:
  - Stimulus: assert i_reset for 1 cycle while waiting on byte 0's i_tx_done.
  - Required: next cycle o_busy=0, o_tx_start=0, o_done=0 and never pulses for the aborted frame. A new i_start=16'h00FF then sends 8'hFF, 8'h00 normally.
